// File: rtl/bus_response_mux.sv
// bus_response_mux: accepts one CPU request at a time, routes it to RAM or IO,
// and returns a single response strobe with data or an error.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid_i/addr/we      CPU request; req_ready_o high only in IDLE
//   bus_addr_o, bus_we_o     latched request, held until the next accept
//   ram_/io_select_i         registered decoder selects, sampled in DECODE
//   ram_/io_rvalid_i/rdata_i target response strobes and read data
//   rsp_valid_o/rdata/err    one-cycle response to the CPU
//   busy_o                   high whenever a transaction is in flight
module bus_response_mux #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    output logic        req_ready_o,
    output logic [31:0] bus_addr_o,
    output logic        bus_we_o,
    input  logic        ram_select_i,
    input  logic        io_select_i,
    input  logic        ram_rvalid_i,
    input  logic        io_rvalid_i,
    input  logic [31:0] ram_rdata_i,
    input  logic [31:0] io_rdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT_RAM,
        S_WAIT_IO,
        S_RESPOND
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          sel_rvalid;
    logic [31:0]   sel_rdata;

    // Only the target chosen in DECODE may answer; the other is ignored.
    assign sel_rvalid = (state_q == S_WAIT_RAM) ? ram_rvalid_i : io_rvalid_i;
    assign sel_rdata  = (state_q == S_WAIT_RAM) ? ram_rdata_i  : io_rdata_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    we_d    = req_we_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cnt_d = '0;
                if (ram_select_i) begin
                    state_d = S_WAIT_RAM;
                end else if (io_select_i) begin
                    state_d = S_WAIT_IO;
                end else begin
                    err_d   = 1'b1;
                    rdata_d = we_q ? 32'h0 : ERR_DATA;
                    state_d = S_RESPOND;
                end
            end
            S_WAIT_RAM, S_WAIT_IO: begin
                // A response arriving on the last allowed cycle beats the timeout.
                if (sel_rvalid) begin
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'h0 : sel_rdata;
                    state_d = S_RESPOND;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = we_q ? 32'h0 : ERR_DATA;
                    state_d = S_RESPOND;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs are gated by rst so they read idle for the whole reset window,
    // including the cycle before the first reset edge is seen.
    assign req_ready_o = !rst && (state_q == S_IDLE);
    assign busy_o      = !rst && (state_q != S_IDLE);
    assign rsp_valid_o = !rst && (state_q == S_RESPOND);
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : 32'h0;
    assign rsp_err_o   = rsp_valid_o ? err_q : 1'b0;
    assign bus_addr_o  = rst ? 32'h0 : addr_q;
    assign bus_we_o    = !rst && we_q;

endmodule

// File: tb/tb_bus_response_mux.sv
// tb_bus_response_mux: directed and randomized transactions checked against
// a transaction-level latency/response model.
module tb_bus_response_mux;

    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic        req_ready_o;
    logic [31:0] bus_addr_o;
    logic        bus_we_o;
    logic        ram_select_i;
    logic        io_select_i;
    logic        ram_rvalid_i;
    logic        io_rvalid_i;
    logic [31:0] ram_rdata_i;
    logic [31:0] io_rdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    bus_response_mux #(
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA(ERR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid_i(req_valid_i),
        .req_addr_i(req_addr_i),
        .req_we_i(req_we_i),
        .req_ready_o(req_ready_o),
        .bus_addr_o(bus_addr_o),
        .bus_we_o(bus_we_o),
        .ram_select_i(ram_select_i),
        .io_select_i(io_select_i),
        .ram_rvalid_i(ram_rvalid_i),
        .io_rvalid_i(io_rvalid_i),
        .ram_rdata_i(ram_rdata_i),
        .io_rdata_i(io_rdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 unmapped, 1 RAM, 2 IO, 3 both selects (RAM wins).
    // k: wait cycle in which the selected target answers; k >= TO means never.
    task automatic run_txn(input logic [31:0] addr, input logic we,
                           input logic [1:0] kind, input int k,
                           input logic [31:0] rdata, input bit hold);
        int          lat;
        logic        exp_e;
        logic [31:0] exp_d;
        bit          mapped;
        bit          to_io;
        bit          hit;
        mapped = (kind != 2'd0);
        to_io  = (kind == 2'd2);
        if (!mapped) begin
            lat   = 1;
            exp_e = 1'b1;
        end else if (k < TO) begin
            lat   = 2 + k;
            exp_e = 1'b0;
        end else begin
            lat   = TO + 1;
            exp_e = 1'b1;
        end
        exp_d = we ? 32'h0 : (exp_e ? ERR : rdata);

        check("ready_idle", req_ready_o, 1);
        req_valid_i  = 1'b1;
        req_addr_i   = addr;
        req_we_i     = we;
        ram_select_i = kind[0];
        io_select_i  = kind[1];
        ram_rvalid_i = 1'($urandom_range(0, 1));
        io_rvalid_i  = 1'($urandom_range(0, 1));
        ram_rdata_i  = $urandom;
        io_rdata_i   = $urandom;
        tick();
        req_valid_i = hold;
        req_addr_i  = $urandom;
        req_we_i    = 1'($urandom_range(0, 1));
        check("busy_acc", busy_o, 1);
        check("ready_acc", req_ready_o, 0);
        check("bus_addr", bus_addr_o, addr);
        check("bus_we", bus_we_o, we);

        for (int c = 1; c <= lat; c++) begin
            ram_rvalid_i = 1'($urandom_range(0, 1));
            io_rvalid_i  = 1'($urandom_range(0, 1));
            ram_rdata_i  = $urandom;
            io_rdata_i   = $urandom;
            if (c >= 2) begin
                ram_select_i = 1'($urandom_range(0, 1));
                io_select_i  = 1'($urandom_range(0, 1));
            end
            if (mapped && c >= 2) begin
                hit = (c == 2 + k);
                if (to_io) begin
                    io_rvalid_i = hit;
                    if (hit) io_rdata_i = rdata;
                end else begin
                    ram_rvalid_i = hit;
                    if (hit) ram_rdata_i = rdata;
                end
            end
            tick();
            if (c < lat) begin
                check("rsp_early", rsp_valid_o, 0);
                check("rdata_idle", rsp_rdata_o, 0);
                check("err_idle", rsp_err_o, 0);
                check("addr_hold", bus_addr_o, addr);
            end else begin
                check("rsp_valid", rsp_valid_o, 1);
                check("rsp_rdata", rsp_rdata_o, exp_d);
                check("rsp_err", rsp_err_o, exp_e);
            end
        end

        ram_rvalid_i = 1'($urandom_range(0, 1));
        io_rvalid_i  = 1'($urandom_range(0, 1));
        tick();
        check("rsp_one", rsp_valid_o, 1'b0);
        check("busy_end", busy_o, 0);
        check("ready_end", req_ready_o, 1);
        check("addr_end", bus_addr_o, addr);
        ram_rvalid_i = 1'b0;
        io_rvalid_i  = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        req_we_i     = 1'b0;
        ram_select_i = 1'b0;
        io_select_i  = 1'b0;
        ram_rvalid_i = 1'b0;
        io_rvalid_i  = 1'b0;
        ram_rdata_i  = '0;
        io_rdata_i   = '0;
        tick();
        tick();
        check("rst_ready", req_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_addr", bus_addr_o, 0);
        check("rst_we", bus_we_o, 0);
        check("rst_rsp", rsp_valid_o, 0);
        check("rst_rdata", rsp_rdata_o, 0);
        check("rst_err", rsp_err_o, 0);
        rst = 1'b0;
        #1;
        check("rel_ready", req_ready_o, 1);

        run_txn(32'h0000_0100, 1'b0, 2'd1, 0, 32'h1234_5678, 1'b0);
        run_txn(32'hF000_0004, 1'b1, 2'd2, 3, 32'h5555_AAAA, 1'b0);
        run_txn(32'h8000_0000, 1'b0, 2'd0, 0, 32'h0, 1'b0);
        run_txn(32'h8000_0008, 1'b1, 2'd0, 0, 32'h0, 1'b0);
        run_txn(32'h0000_0200, 1'b0, 2'd1, TO, 32'h0, 1'b0);
        run_txn(32'h0000_0204, 1'b1, 2'd2, TO, 32'h0, 1'b0);
        run_txn(32'h0000_0208, 1'b0, 2'd1, TO - 1, 32'hCAFE_F00D, 1'b0);
        run_txn(32'h0000_020C, 1'b0, 2'd3, 1, 32'h0BAD_F00D, 1'b1);
        run_txn(32'h0000_0210, 1'b0, 2'd2, 2, 32'h7777_0001, 1'b1);

        for (int i = 0; i < 60; i++) begin
            int   k;
            logic [1:0] kind;
            kind = 2'($urandom_range(0, 3));
            k    = ($urandom_range(0, 3) == 0) ? TO - 1 : $urandom_range(0, TO + 3);
            run_txn($urandom, 1'($urandom_range(0, 1)), kind, k, $urandom,
                    1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a RAM wait, then a late rvalid.
        req_valid_i  = 1'b1;
        req_addr_i   = 32'h0000_0300;
        req_we_i     = 1'b0;
        ram_select_i = 1'b1;
        io_select_i  = 1'b0;
        tick();
        req_valid_i = 1'b0;
        tick();
        tick();
        check("wait_busy", busy_o, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_ready", req_ready_o, 0);
        check("mid_rst_addr", bus_addr_o, 0);
        tick();
        check("mid_rst_rsp", rsp_valid_o, 0);
        rst          = 1'b0;
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 32'hFFFF_0000;
        #1;
        check("post_rst_ready", req_ready_o, 1);
        tick();
        ram_rvalid_i = 1'b0;
        check("late_rv_busy", busy_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("late_rv_rsp", rsp_valid_o, 0);
        end
        run_txn(32'h0000_0400, 1'b0, 2'd1, 4, 32'h2468_ACE0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
